// File: rtl/ascii_to_ps2_tx.sv
// ascii_to_ps2_tx: keyboard-side PS/2 transmitter.
// Accepts one ASCII character per valid/ready handshake and maps it to its
// set-2 scan code. It then drives device-to-host frames on ps2c/ps2d.
// Each frame is: start 0, 8 data bits LSB first, odd parity, stop 1.
//
// Build option: define ASCII_TX_BREAK_EN to send the full make + F0 + make
// sequence (3 frames). Without it, only the make frame is sent.
//
// Gap timing: LOAD is a single idle cycle, and GAP holds the lines idle for
// GAP_CYCLES-1 cycles. Between frames the idle time is therefore exactly
// GAP_CYCLES. A complete frame slot is 1 + 22*CLK_DIV + GAP_CYCLES-1 cycles.
// GAP_CYCLES must be at least 2.
module ascii_to_ps2_tx #(
    parameter int CLK_DIV    = 3333,
    parameter int GAP_CYCLES = 6666
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ascii_in,
    input  logic       ascii_valid,
    output logic       ascii_ready,
    output logic       ps2c,
    output logic       ps2d,
    output logic       busy,
    output logic       unmapped
);
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 2);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP, GAP} state_t;

    state_t        state, state_nxt;
    logic          half, half_nxt;          // 0: clock-high half, 1: clock-low half
    logic [CW-1:0] hcnt, hcnt_nxt;
    logic [2:0]    bitidx, bitidx_nxt;
    logic [GW-1:0] gcnt, gcnt_nxt;
    logic          ps2c_nxt, ps2d_nxt, busy_nxt, ready_nxt, unmapped_nxt;
    logic [7:0]    code_r;                  // scan code of the accepted character
    logic [7:0]    frame_r;                 // byte currently being serialised
    logic [8:0]    lookup;
    logic          accept;
    logic          last_frame;

`ifdef ASCII_TX_BREAK_EN
    logic [1:0]    fidx, fidx_nxt;          // 0: make, 1: F0, 2: make again
    assign last_frame = (fidx == 2'd2);
`else
    assign last_frame = 1'b1;
`endif

    // Returns {mapped, scan_code}; folding bit 5 makes the match case-insensitive
    function automatic logic [8:0] map_ascii(input logic [7:0] c);
        case (c | 8'h20)
            8'h61:   map_ascii = {1'b1, 8'h1C};   // A
            8'h64:   map_ascii = {1'b1, 8'h23};   // D
            8'h66:   map_ascii = {1'b1, 8'h2B};   // F
            8'h68:   map_ascii = {1'b1, 8'h33};   // H
            8'h72:   map_ascii = {1'b1, 8'h2D};   // R
            8'h74:   map_ascii = {1'b1, 8'h2C};   // T
            default: map_ascii = 9'h000;
        endcase
    endfunction

    assign lookup = map_ascii(ascii_in);
    assign accept = ascii_valid && ascii_ready;

    // Next-state logic; the line values are derived from the next state so the
    // registered ps2c/ps2d always match the state they belong to
    always_comb begin
        state_nxt    = state;
        half_nxt     = half;
        hcnt_nxt     = hcnt;
        bitidx_nxt   = bitidx;
        gcnt_nxt     = gcnt;
        unmapped_nxt = 1'b0;
`ifdef ASCII_TX_BREAK_EN
        fidx_nxt     = fidx;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    if (lookup[8]) begin
                        state_nxt = LOAD;
`ifdef ASCII_TX_BREAK_EN
                        fidx_nxt  = 2'd0;
`endif
                    end else begin
                        unmapped_nxt = 1'b1;
                    end
                end
            end
            LOAD: begin
                state_nxt = START;
                half_nxt  = 1'b0;
                hcnt_nxt  = '0;
            end
            START, DATA, PARITY, STOP: begin
                if (hcnt == HALF_LAST) begin
                    hcnt_nxt = '0;
                    half_nxt = ~half;
                    if (half) begin
                        case (state)
                            START: begin
                                state_nxt  = DATA;
                                bitidx_nxt = 3'd0;
                            end
                            DATA: begin
                                if (bitidx == 3'd7) state_nxt = PARITY;
                                else                bitidx_nxt = bitidx + 3'd1;
                            end
                            PARITY:  state_nxt = STOP;
                            default: begin
                                state_nxt = GAP;
                                gcnt_nxt  = '0;
                            end
                        endcase
                    end
                end else begin
                    hcnt_nxt = hcnt + 1'b1;
                end
            end
            GAP: begin
                if (gcnt == GAP_LAST) begin
                    state_nxt = last_frame ? IDLE : LOAD;
`ifdef ASCII_TX_BREAK_EN
                    fidx_nxt  = fidx + 2'd1;
`endif
                end else begin
                    gcnt_nxt = gcnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        ps2c_nxt = 1'b1;
        ps2d_nxt = 1'b1;
        case (state_nxt)
            START:  begin ps2c_nxt = ~half_nxt; ps2d_nxt = 1'b0;               end
            DATA:   begin ps2c_nxt = ~half_nxt; ps2d_nxt = frame_r[bitidx_nxt]; end
            PARITY: begin ps2c_nxt = ~half_nxt; ps2d_nxt = ~^frame_r;          end
            STOP:   begin ps2c_nxt = ~half_nxt; ps2d_nxt = 1'b1;               end
            default: ;
        endcase
        busy_nxt  = (state_nxt != IDLE);
        ready_nxt = (state_nxt == IDLE) && !unmapped_nxt;
    end

    // Control state and registered line outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            half        <= 1'b0;
            hcnt        <= '0;
            bitidx      <= 3'd0;
            gcnt        <= '0;
            ps2c        <= 1'b1;
            ps2d        <= 1'b1;
            busy        <= 1'b0;
            ascii_ready <= 1'b1;
            unmapped    <= 1'b0;
`ifdef ASCII_TX_BREAK_EN
            fidx        <= 2'd0;
`endif
        end else begin
            state       <= state_nxt;
            half        <= half_nxt;
            hcnt        <= hcnt_nxt;
            bitidx      <= bitidx_nxt;
            gcnt        <= gcnt_nxt;
            ps2c        <= ps2c_nxt;
            ps2d        <= ps2d_nxt;
            busy        <= busy_nxt;
            ascii_ready <= ready_nxt;
            unmapped    <= unmapped_nxt;
`ifdef ASCII_TX_BREAK_EN
            fidx        <= fidx_nxt;
`endif
        end
    end

    // Data registers: scan code captured at acceptance, frame byte chosen in LOAD
    always_ff @(posedge clk) begin
        if (state == IDLE && accept && lookup[8]) code_r <= lookup[7:0];
        if (state == LOAD) begin
`ifdef ASCII_TX_BREAK_EN
            frame_r <= (fidx == 2'd1) ? 8'hF0 : code_r;
`else
            frame_r <= code_r;
`endif
        end
    end
endmodule

// File: tb/tb_ascii_to_ps2_tx.sv
// Testbench for ascii_to_ps2_tx (CLK_DIV=4, GAP_CYCLES=8).
// A waveform-level model predicts {busy, ready, ps2c, ps2d, unmapped} every
// cycle. A host-style receiver samples ps2d on ps2c falling edges. Directed
// literal checks pin the received bytes and the busy durations.
module tb_ascii_to_ps2_tx;
    localparam int CD  = 4;
    localparam int GAP = 8;
`ifdef ASCII_TX_BREAK_EN
    localparam int NF = 3;
`else
    localparam int NF = 1;
`endif
    localparam logic [4:0] IDLE_V = 5'b01110;   // {busy, ready, ps2c, ps2d, unmapped}

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ascii_in;
    logic       ascii_valid;
    logic       ascii_ready, ps2c, ps2d, busy, unmapped;

    ascii_to_ps2_tx #(.CLK_DIV(CD), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(reset), .ascii_in(ascii_in), .ascii_valid(ascii_valid),
        .ascii_ready(ascii_ready), .ps2c(ps2c), .ps2d(ps2d), .busy(busy), .unmapped(unmapped)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errs = 0;
    int         cyc = 0;
    bit         checking = 0;
    logic [4:0] expq[$];
    logic [7:0] rx_q[$];
    logic [7:0] exp_rx[$];
    logic [10:0] rxbits;
    int         rxn = 0;
    logic       prev_c = 1'b1;
    int         busy_run = 0;
    int         last_run = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Set-2 scan code table, both letter cases listed explicitly
    function automatic logic [8:0] scan_of(input logic [7:0] c);
        case (c)
            8'h41, 8'h61: scan_of = {1'b1, 8'h1C};
            8'h44, 8'h64: scan_of = {1'b1, 8'h23};
            8'h46, 8'h66: scan_of = {1'b1, 8'h2B};
            8'h48, 8'h68: scan_of = {1'b1, 8'h33};
            8'h52, 8'h72: scan_of = {1'b1, 8'h2D};
            8'h54, 8'h74: scan_of = {1'b1, 8'h2C};
            default:      scan_of = 9'h000;
        endcase
    endfunction

    // Expected per-cycle outputs for one accepted character
    task automatic model_accept(input logic [7:0] c);
        logic [8:0]  m;
        logic [7:0]  b;
        logic [10:0] bits;
        m = scan_of(c);
        if (!m[8]) begin
            expq.push_back(5'b00111);
            return;
        end
        for (int f = 0; f < NF; f++) begin
            b = (f == 1) ? 8'hF0 : m[7:0];
            bits = {1'b1, ~^b, b, 1'b0};
            expq.push_back(5'b10110);                      // one idle cycle before each frame
            for (int i = 0; i < 11; i++)
                for (int h = 0; h < 2 * CD; h++)
                    expq.push_back({2'b10, (h < CD), bits[i], 1'b0});
            for (int g = 0; g < GAP - 1; g++)
                expq.push_back(5'b10110);
        end
    endtask

    // One clock cycle: compare at negedge, then advance to just after the next posedge
    task automatic step();
        logic [4:0] e;
        @(negedge clk);
        cyc++;
        e = IDLE_V;
        if (checking) begin
            if (expq.size() > 0) e = expq.pop_front();
            chk($sformatf("cycle%0d outputs", cyc), {busy, ready_w(), ps2c, ps2d, unmapped}, e);
        end
        if (reset) begin
            rxn = 0;
            prev_c = 1'b1;
        end else begin
            if (prev_c && !ps2c) begin
                rxbits[rxn] = ps2d;
                rxn++;
                if (rxn == 11) begin
                    chk("rx_frame start/stop/parity", {rxbits[0], rxbits[10], ^rxbits[9:1]}, 3'b011);
                    rx_q.push_back(rxbits[8:1]);
                    rxn = 0;
                end
            end
            prev_c = ps2c;
        end
        if (busy === 1'b1) busy_run++;
        else if (busy_run > 0) begin
            last_run = busy_run;
            busy_run = 0;
        end
        if (reset) expq.delete();
        else if (checking && e[3] && ascii_valid) model_accept(ascii_in);
        @(posedge clk);
        #1;
    endtask

    function automatic logic ready_w();
        return ascii_ready;
    endfunction

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (!(ascii_ready && !busy) && n < limit) begin
            step();
            n++;
        end
        chk("wait_idle within bound", (n < limit), 1);
        step();
    endtask

    task automatic send(input logic [7:0] c);
        ascii_valid = 1'b1;
        ascii_in = c;
        step();
        ascii_valid = 1'b0;
        ascii_in = 8'h54;                                   // changes after acceptance
    endtask

    task automatic add_exp(input logic [7:0] code);
        exp_rx.push_back(code);
        if (NF == 3) begin
            exp_rx.push_back(8'hF0);
            exp_rx.push_back(code);
        end
    endtask

    task automatic check_rx(input string name);
        chk({name, " frame count"}, rx_q.size(), exp_rx.size());
        for (int i = 0; i < exp_rx.size() && i < rx_q.size(); i++)
            chk($sformatf("%s byte%0d", name, i), rx_q[i], exp_rx[i]);
        rx_q.delete();
        exp_rx.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        ascii_valid = 1'b0;
        ascii_in = 8'h00;
        step();
        checking = 1;
        step();
        step();
        reset = 1'b0;
        chk("reset ps2c", ps2c, 1);
        chk("reset ps2d", ps2d, 1);
        chk("reset ready", ascii_ready, 1);
        chk("reset busy", busy, 0);
        step();

        // 'A' -> 1C (parity 0), F0 (parity 1), 1C
        send(8'h41);
        wait_idle(400);
        add_exp(8'h1C);
        check_rx("A");
        chk("A busy cycles", last_run, (NF == 3) ? 288 : 96);

        // 'h' -> 33 (parity 1), F0, 33
        send(8'h68);
        wait_idle(400);
        add_exp(8'h33);
        check_rx("h");
        chk("h busy cycles", last_run, (NF == 3) ? 288 : 96);

        // '1' is unmapped: one-cycle pulse, no frame
        send(8'h31);
        chk("1 unmapped pulse", unmapped, 1);
        chk("1 ready low", ascii_ready, 0);
        chk("1 lines idle", {ps2c, ps2d}, 2'b11);
        step();
        chk("1 unmapped cleared", unmapped, 0);
        chk("1 ready back", ascii_ready, 1);
        chk("1 busy", busy, 0);
        step();
        check_rx("1");

        // 'R' then 'T' with valid held across the sequence
        ascii_valid = 1'b1;
        ascii_in = 8'h52;
        step();
        ascii_in = 8'h54;
        begin
            int n;
            n = 0;
            while (busy && n < 400) begin step(); n++; end
            chk("RT first busy ends", (n < 400), 1);
            n = 0;
            while (!busy && n < 5) begin step(); n++; end
            chk("RT second accept", (n < 5), 1);
        end
        ascii_valid = 1'b0;
        wait_idle(400);
        add_exp(8'h2D);
        add_exp(8'h2C);
        check_rx("RT");

        // Reset in the clock-low half of data bit 3 of the first frame of 'D'
        send(8'h44);
        for (int k = 0; k < 38; k++) step();
        chk("pre-reset bits sampled", rxn, 5);
        chk("pre-reset lines low", {ps2c, ps2d}, 2'b00);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort lines", {ps2c, ps2d}, 2'b11);
        chk("abort busy", busy, 0);
        chk("abort ready", ascii_ready, 1);
        step();
        check_rx("abort");

        // Fresh 'D' -> 23, F0, 23
        send(8'h44);
        wait_idle(400);
        add_exp(8'h23);
        check_rx("D");
        chk("D busy cycles", last_run, (NF == 3) ? 288 : 96);

        // Lowercase 'f' -> 2B
        send(8'h66);
        wait_idle(400);
        add_exp(8'h2B);
        check_rx("f");

        for (int k = 0; k < 4; k++) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end
endmodule

// File: doc/ascii_to_ps2_tx.md
Name: ascii_to_ps2_tx

Overview:
- Keyboard-side PS/2 transmitter. Inverse of the scan-code-to-ASCII decode path.
- Accepts one ASCII byte per valid/ready handshake and maps it to its set-2 scan code.
- Serialises the make code, then the break sequence F0 + code, as standard PS/2 device frames on generated ps2c/ps2d lines.
- Used as a keyboard emulator for loopback tests of the receive/decode chain and for board self-test.

Parameters:
- CLK_DIV, 3333, system-clock cycles per PS/2 clock half-period (100 MHz gives ~15 kHz).
- GAP_CYCLES, 6666, idle cycles (both lines high) inserted after every frame.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ascii_in  in  8  ASCII character to send
- ascii_valid  in  1  ascii_in is valid
- ascii_ready  out  1  block can accept a character
- ps2c  out  1  PS/2 clock, idle 1
- ps2d  out  1  PS/2 data, idle 1
- busy  out  1  sequence in progress
- unmapped  out  1  one-cycle pulse: accepted character has no scan code

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high.
- Reset values: ps2c=1, ps2d=1, ascii_ready=1, busy=0, unmapped=0, FSM=IDLE, all counters 0.
- Reset asserted mid-frame: lines return to 1 on the next edge and the frame is abandoned.
- Handshake:
  - Accept when ascii_valid && ascii_ready.
  - ascii_ready=1 only in IDLE. It drops on the cycle after acceptance.
  - ascii_in is registered at acceptance and may change afterwards.
- Mapping, uppercase or lowercase accepted: A/a->1C, D/d->23, F/f->2B, H/h->33, R/r->2D, T/t->2C.
- Any other character:
  - unmapped pulses high the cycle after acceptance.
  - No frame is sent and the FSM stays in IDLE.
- Frame sequence for a mapped character: code, F0, code. Each frame is followed by GAP_CYCLES idle cycles.
- FSM: IDLE -> LOAD -> START -> DATA(x8) -> PARITY -> STOP -> GAP -> (LOAD for the next frame | IDLE after the last).
- Bit timing:
  - Each bit: ps2d is updated on entry to the bit, then ps2c is high for CLK_DIV cycles, then low for CLK_DIV cycles.
  - Data is therefore stable across the falling edge the host samples.
- Frame content: start bit 0, 8 data bits LSB first, odd parity (parity bit = ~^byte), stop bit 1.
- Frame = 11 bits = 22*CLK_DIV cycles.
- busy=1 from the cycle after acceptance until GAP of the final frame completes.
- ascii_ready rises in the same cycle busy falls.
- ascii_valid held high across a sequence: next character is accepted only after returning to IDLE. No queuing.
- Counters:
  - Half-period counter wraps at CLK_DIV-1.
  - Bit index is 0..7. No other wrap-around.
- ps2c/ps2d are registered outputs with no combinational path from the inputs.

Optional Feature:
- Macro ASCII_TX_BREAK_EN.
- Defined: the full make + F0 + code sequence is sent (3 frames).
- Undefined:
  - Only the make code frame is sent (1 frame).
  - busy falls after that frame's GAP.
  - Break-sequence logic is removed.

Test Plan:
- Reset behaviour: CLK_DIV=4, GAP_CYCLES=8; hold reset 3 cycles -> ps2c=ps2d=1, ascii_ready=1, busy=0.
- Send 'A' (8'h41):
  - Falling-edge samples give frames 1C (parity 0), F0 (parity 1), 1C.
  - Each frame is 88 cycles followed by an 8-cycle gap.
  - busy high for 288 cycles after acceptance (without ASCII_TX_BREAK_EN: 1C only, 96 cycles).
- Send 'h' (8'h68): frames 33 (parity 1), F0, 33.
- Send '1' (8'h31): unmapped=1 for exactly one cycle; ps2c/ps2d stay 1; ascii_ready back to 1 on the next cycle.
- Hold ascii_valid with 'R' then 'T' back-to-back:
  - 'T' is accepted only after busy falls.
  - Output is 2D,F0,2D followed by 2C,F0,2C, with no interleaving.
- Assert reset during DATA bit 3 of the first frame -> lines=1 the next cycle, busy=0, and a fresh 'D' afterwards sends 23,F0,23 correctly.
- Loopback: feed ps2c/ps2d into the team's PS/2 receiver and scan-code decode -> decoded ASCII matches every mapped character sent.
